drp_dcm_reconfig: RTL and testbench

//  DRP initiator that reprograms the CLKFX multiply/divide of the drp_dcm DCM_ADV at run time.

---
 rtl/drp_dcm_reconfig_if.sv | 12 +
 rtl/drp_dcm_reconfig.sv | 260 ++++++++++++++++++++++++++
 tb/tb_drp_dcm_reconfig.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/drp_dcm_reconfig_if.sv
// DRP bus between the CLKFX reconfiguration initiator (master) and drp_dcm (slave).
interface drp_dcm_reconfig_if;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic        den;
    logic        dwe;
    logic [15:0] dout;
    logic        drdy;

    modport master (output daddr, di, den, dwe, input dout, drdy);
    modport slave  (input daddr, di, den, dwe, output dout, drdy);
endinterface

// File: rtl/drp_dcm_reconfig.sv
// DRP initiator that reprograms the DCM_ADV CLKFX multiply/divide at run time.
// Optional read-back check of the written M/D word: define DRP_READBACK_VERIFY_EN.
module drp_dcm_reconfig #(
    parameter logic [6:0]  FX_ADDR      = 7'h50,
    parameter int unsigned RST_HOLD     = 8,
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic                      dclk,
    input  logic                      rst_n_in,
    input  logic                      start_in,
    input  logic [7:0]                mult_in,
    input  logic [7:0]                div_in,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      error_out,
    output logic [1:0]                err_code_out,
    drp_dcm_reconfig_if.master        drp,
    output logic                      dcm_rst_out,
    input  logic                      locked_in
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_CHECK     = 4'd1;
    localparam logic [3:0] ST_RST_HOLD  = 4'd2;
    localparam logic [3:0] ST_WR        = 4'd3;
    localparam logic [3:0] ST_WR_WAIT   = 4'd4;
    localparam logic [3:0] ST_RELEASE   = 4'd5;
    localparam logic [3:0] ST_LOCK_WAIT = 4'd6;
`ifdef DRP_READBACK_VERIFY_EN
    localparam logic [3:0] ST_RD        = 4'd7;
    localparam logic [3:0] ST_RD_WAIT   = 4'd8;
`endif

    localparam logic [1:0] ERR_MD    = 2'd1;
    localparam logic [1:0] ERR_DRDY  = 2'd2;
    localparam logic [1:0] ERR_LOCK  = 2'd3;

    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);
    localparam logic [15:0] DRDY_LAST = 16'(DRDY_TIMEOUT - 1);
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

    // CLKFX limits of the DCM_ADV: M in 2..32, D in 1..32
    function automatic logic md_legal(input logic [7:0] m, input logic [7:0] d);
        return (m >= 8'd2) && (m <= 8'd32) && (d >= 8'd1) && (d <= 8'd32);
    endfunction

    function automatic logic [15:0] md_word(input logic [7:0] m, input logic [7:0] d);
        return {m - 8'd1, d - 8'd1};
    endfunction

    logic [3:0]  state_q,    state_d;
    logic [15:0] cnt_q,      cnt_d;
    logic [7:0]  m_q,        m_d;
    logic [7:0]  dv_q,       dv_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        error_q,    error_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        den_q,      den_d;
    logic        dwe_q,      dwe_d;
    logic [6:0]  daddr_q,    daddr_d;
    logic [15:0] di_q,       di_d;
    logic        dcm_rst_q,  dcm_rst_d;
    logic [1:0]  sync_q,     sync_d;
    logic        fail_s;
    logic [1:0]  fail_code_s;
    logic        locked_sync_s;

    assign locked_sync_s = sync_q[1];

    // LOCKED is asynchronous to dclk: two-flop synchronizer shift
    always_comb begin
        sync_d = {sync_q[0], locked_in};
    end

    // Sequencer next-state, counter and output-register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_d         = m_q;
        dv_d        = dv_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_code_d  = err_code_q;
        den_d       = 1'b0;
        dwe_d       = 1'b0;
        daddr_d     = daddr_q;
        di_d        = di_q;
        dcm_rst_d   = dcm_rst_q;
        fail_s      = 1'b0;
        fail_code_s = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    m_d        = mult_in;
                    dv_d       = div_in;
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                    state_d    = ST_CHECK;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!md_legal(m_q, dv_q)) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_MD;
                end else begin
                    state_d     = ST_RST_HOLD;
                    cnt_d       = 16'd0;
                    dcm_rst_d   = 1'b1;
                end
            end
            ST_RST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WR;
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    daddr_d = FX_ADDR;
                    di_d    = md_word(m_q, dv_q);
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_WR: begin
                state_d = ST_WR_WAIT;
                cnt_d   = 16'd0;
            end
            ST_WR_WAIT: begin
                if (drp.drdy) begin
`ifdef DRP_READBACK_VERIFY_EN
                    state_d   = ST_RD;
                    den_d     = 1'b1;
                    dwe_d     = 1'b0;
                    daddr_d   = FX_ADDR;
`else
                    state_d   = ST_RELEASE;
                    dcm_rst_d = 1'b0;
`endif
                end else if (cnt_q == DRDY_LAST) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_DRDY;
                end else begin
                    cnt_d       = cnt_q + 16'd1;
                end
            end
`ifdef DRP_READBACK_VERIFY_EN
            ST_RD: begin
                state_d = ST_RD_WAIT;
                cnt_d   = 16'd0;
            end
            ST_RD_WAIT: begin
                if (drp.drdy) begin
                    if (drp.dout == di_q) begin
                        state_d     = ST_RELEASE;
                        dcm_rst_d   = 1'b0;
                    end else begin
                        fail_s      = 1'b1;
                        fail_code_s = ERR_LOCK;
                    end
                end else if (cnt_q == DRDY_LAST) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_DRDY;
                end else begin
                    cnt_d       = cnt_q + 16'd1;
                end
            end
`endif
            ST_RELEASE: begin
                dcm_rst_d = 1'b0;
                state_d   = ST_LOCK_WAIT;
                cnt_d     = 16'd0;
            end
            ST_LOCK_WAIT: begin
                if (locked_sync_s) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else if (cnt_q == LOCK_LAST) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_LOCK;
                end else begin
                    cnt_d       = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                dcm_rst_d = 1'b0;
            end
        endcase

        // Every error path ends the same way; the DCM keeps whatever was last written
        if (fail_s) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = fail_code_s;
            dcm_rst_d  = 1'b0;
        end else begin
            error_d    = error_d;
        end
    end

    // State and output registers; reset abandons any in-flight DRP access
    always_ff @(posedge dclk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            m_q        <= 8'd0;
            dv_q       <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= 7'd0;
            di_q       <= 16'd0;
            dcm_rst_q  <= 1'b0;
            sync_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            dv_q       <= dv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            daddr_q    <= daddr_d;
            di_q       <= di_d;
            dcm_rst_q  <= dcm_rst_d;
            sync_q     <= sync_d;
        end
    end

    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign error_out    = error_q;
    assign err_code_out = err_code_q;
    assign dcm_rst_out  = dcm_rst_q;
    assign drp.den      = den_q;
    assign drp.dwe      = dwe_q;
    assign drp.daddr    = daddr_q;
    assign drp.di       = di_q;

`ifndef DRP_READBACK_VERIFY_EN
    logic unused_dout_s;
    assign unused_dout_s = ^drp.dout;
`endif

endmodule

// File: tb/tb_drp_dcm_reconfig.sv
// Directed bench for drp_dcm_reconfig: DRP slave and DCM lock behaviour modelled per cycle.
module tb_drp_dcm_reconfig;

    logic       dclk = 1'b0;
    logic       rst_n_in;
    logic       start_in;
    logic [7:0] mult_in;
    logic [7:0] div_in;
    logic       busy_out;
    logic       done_out;
    logic       error_out;
    logic [1:0] err_code_out;
    logic       dcm_rst_out;
    logic       locked_in;

    drp_dcm_reconfig_if drp_bus ();

    drp_dcm_reconfig dut (
        .dclk         (dclk),
        .rst_n_in     (rst_n_in),
        .start_in     (start_in),
        .mult_in      (mult_in),
        .div_in       (div_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .error_out    (error_out),
        .err_code_out (err_code_out),
        .drp          (drp_bus.master),
        .dcm_rst_out  (dcm_rst_out),
        .locked_in    (locked_in)
    );

    always #5 dclk = ~dclk;

`ifdef DRP_READBACK_VERIFY_EN
    localparam int EXP_DEN = 2;
`else
    localparam int EXP_DEN = 1;
`endif

    int checks = 0;
    int passes = 0;

    // slave / DCM model knobs and per-transaction observations
    int          drdy_lat = 3;
    bit          drdy_en  = 1'b1;
    int          lock_lat = 100;
    bit          lock_en  = 1'b1;
    bit          dout_bad = 1'b0;
    int          drdy_cd  = 0;
    int          rel_cnt  = 0;
    logic [15:0] wr_data  = 16'h0000;
    int          cyc, den_cnt, wr_cnt, done_cnt, rst_hi_before_den;
    int          den_cyc, err_cyc, rst_fall_cyc, done_cyc;
    bit          rst_ever, prev_rst, prev_err;
    logic [15:0] cap_di;
    logic [6:0]  cap_addr;
    logic        cap_rst_at_den;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    endtask

    // advance to the next falling edge, then play the DRP slave and the DCM
    task automatic step();
        @(negedge dclk);
        cyc++;
        drp_bus.drdy = 1'b0;
        if (drdy_cd > 0) begin
            drdy_cd--;
            if (drdy_cd == 0) drp_bus.drdy = 1'b1;
        end
        if (drp_bus.den === 1'b1) begin
            den_cnt++;
            den_cyc = cyc;
            if (drp_bus.dwe === 1'b1) begin
                wr_cnt++;
                cap_di         = drp_bus.di;
                cap_addr       = drp_bus.daddr;
                cap_rst_at_den = dcm_rst_out;
                wr_data        = drp_bus.di;
            end else begin
                drp_bus.dout = dout_bad ? 16'h0300 : wr_data;
            end
            if (drdy_en) drdy_cd = drdy_lat;
        end
        if (dcm_rst_out === 1'b1) begin
            rst_ever = 1'b1;
            if (den_cnt == 0) rst_hi_before_den++;
            rel_cnt = 0;
        end else begin
            if (prev_rst) rst_fall_cyc = cyc;
            rel_cnt++;
        end
        prev_rst  = (dcm_rst_out === 1'b1);
        locked_in = lock_en && (dcm_rst_out === 1'b0) && (rel_cnt >= lock_lat);
        if (done_out === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (error_out === 1'b1 && !prev_err) err_cyc = cyc;
        prev_err = (error_out === 1'b1);
    endtask

    task automatic go(input logic [7:0] m, input logic [7:0] d);
        cyc = 0; den_cnt = 0; wr_cnt = 0; done_cnt = 0; rst_hi_before_den = 0;
        den_cyc = -1; err_cyc = -1; rst_fall_cyc = -1; done_cyc = -1;
        rst_ever = 1'b0; cap_di = 16'hxxxx; cap_rst_at_den = 1'bx;
        mult_in = m; div_in = d; start_in = 1'b1;
        step();
        start_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_out === 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("idle_within_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"},  32'(busy_out),     32'd0);
        chk({name, "_done"},  32'(done_out),     32'd0);
        chk({name, "_err"},   32'(error_out),    32'd0);
        chk({name, "_code"},  32'(err_code_out), 32'd0);
        chk({name, "_den"},   32'(drp_bus.den),  32'd0);
        chk({name, "_dwe"},   32'(drp_bus.dwe),  32'd0);
        chk({name, "_rst"},   32'(dcm_rst_out),  32'd0);
    endtask

    initial begin
        rst_n_in = 1'b0; start_in = 1'b0; mult_in = 8'd0; div_in = 8'd0;
        locked_in = 1'b0; drp_bus.drdy = 1'b0; drp_bus.dout = 16'h0000;
        prev_rst = 1'b0; prev_err = 1'b0; cyc = 0;
        den_cnt = 0; wr_cnt = 0; done_cnt = 0; rst_hi_before_den = 0;
        repeat (3) step();
        chk_all_zero("reset");
        rst_n_in = 1'b1;
        repeat (2) step();

        // M=4 D=2, drdy 3 cycles after den, lock 100 cycles after release
        go(8'd4, 8'd2);
        chk("A_busy_on_accept", 32'(busy_out), 32'd1);
        mult_in = 8'd1; div_in = 8'd2; start_in = 1'b1;
        step();
        start_in = 1'b0;
        wait_idle(400);
        chk("A_di",          32'(cap_di),   32'h0301);
        chk("A_daddr",       32'(cap_addr), 32'h50);
        chk("A_rst_at_den",  32'(cap_rst_at_den), 32'd1);
        chk("A_rst_hold",    32'(rst_hi_before_den), 32'd8);
        chk("A_den_count",   32'(den_cnt),  32'(EXP_DEN));
        chk("A_done_pulses", 32'(done_cnt), 32'd1);
        chk("A_lock_lat",    32'((done_cyc - rst_fall_cyc >= 100) && (done_cyc - rst_fall_cyc <= 104)), 32'd1);
        chk("A_err",         32'(error_out), 32'd0);
        chk("A_rst_after",   32'(dcm_rst_out), 32'd0);
        step();
        chk("A_done_1cycle", 32'(done_out), 32'd0);
        chk("A_done_total",  32'(done_cnt), 32'd1);

        // illegal M=1: code 1 the cycle after CHECK, no DRP, no DCM reset
        go(8'd1, 8'd2);
        wait_idle(10);
        repeat (3) step();
        chk("B_code",     32'(err_code_out), 32'd1);
        chk("B_err",      32'(error_out), 32'd1);
        chk("B_err_cyc",  32'(err_cyc), 32'd2);
        chk("B_no_den",   32'(den_cnt), 32'd0);
        chk("B_no_rst",   32'(rst_ever), 32'd0);

        go(8'd33, 8'd1);
        wait_idle(10);
        chk("B_m33_code", 32'(err_code_out), 32'd1);
        go(8'd2, 8'd0);
        wait_idle(10);
        chk("B_d0_code",  32'(err_code_out), 32'd1);

        // M=8 D=1 with drdy never returned
        drdy_en = 1'b0;
        go(8'd8, 8'd1);
        wait_idle(200);
        chk("C_code",      32'(err_code_out), 32'd2);
        chk("C_err",       32'(error_out), 32'd1);
        chk("C_busy",      32'(busy_out), 32'd0);
        chk("C_rst",       32'(dcm_rst_out), 32'd0);
        chk("C_di",        32'(cap_di), 32'h0700);
        chk("C_timeout",   32'((err_cyc - den_cyc >= 64) && (err_cyc - den_cyc <= 66)), 32'd1);
        chk("C_no_done",   32'(done_cnt), 32'd0);
        drdy_en = 1'b1;

        // M=32 D=32 with LOCKED never rising
        lock_en = 1'b0;
        go(8'd32, 8'd32);
        wait_idle(70000);
        chk("D_code",      32'(err_code_out), 32'd3);
        chk("D_err",       32'(error_out), 32'd1);
        chk("D_di",        32'(cap_di), 32'h1F1F);
        chk("D_timeout",   32'((err_cyc - rst_fall_cyc >= 65535) && (err_cyc - rst_fall_cyc <= 65538)), 32'd1);
        chk("D_no_done",   32'(done_cnt), 32'd0);
        lock_en = 1'b1;
        go(8'd4, 8'd2);
        chk("D_err_cleared",  32'(error_out), 32'd0);
        chk("D_code_cleared", 32'(err_code_out), 32'd0);
        wait_idle(400);
        chk("D_retry_done",   32'(done_cnt), 32'd1);

        // async reset in LOCK_WAIT, then a fresh request
        lock_lat = 1000;
        go(8'd5, 8'd3);
        begin
            int n = 0;
            while (rst_fall_cyc < 0 && n < 200) begin
                step();
                n++;
            end
            chk("E_reached_lockwait", 32'(n < 200), 32'd1);
        end
        repeat (20) step();
        chk("E_busy_before", 32'(busy_out), 32'd1);
        #1 rst_n_in = 1'b0;
        #1;
        chk_all_zero("E_async");
        drdy_cd = 0;
        lock_lat = 100;
        repeat (2) step();
        rst_n_in = 1'b1;
        step();
        go(8'd4, 8'd2);
        wait_idle(400);
        chk("E_fresh_done", 32'(done_cnt), 32'd1);
        chk("E_fresh_di",   32'(cap_di), 32'h0301);
        chk("E_fresh_err",  32'(error_out), 32'd0);

`ifdef DRP_READBACK_VERIFY_EN
        // read-back returns 16'h0300 against the written 16'h0301
        dout_bad = 1'b1;
        go(8'd4, 8'd2);
        wait_idle(400);
        chk("F_code",    32'(err_code_out), 32'd3);
        chk("F_no_done", 32'(done_cnt), 32'd0);
        chk("F_rst",     32'(dcm_rst_out), 32'd0);
        dout_bad = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
